// File: rtl/amul_pkg.sv
// Shared types and widths for the approximate-multiplier dot-product sequencer.
package amul_pkg;

    // Sequencer states; encoding is visible on the fsm_state debug output.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width of one signed 8x8 product.
    localparam int MUL_W = 16;
    // Width of a product difference: two 16-bit products can differ by up to 17 bits.
    localparam int ERR_W = 17;

    // Magnitude of a signed product difference. The most negative 17-bit value
    // cannot occur because both operands of the difference are 16-bit products.
    function automatic logic [ERR_W-1:0] abs_err(input logic signed [ERR_W-1:0] d);
        logic [ERR_W-1:0] mag;
        mag = d[ERR_W-1] ? ERR_W'(-d) : ERR_W'(d);
        return mag;
    endfunction

endpackage

// File: rtl/amul8x8.sv
// Signed 8x8 multiplier producing the exact product and an approximate product.
// The approximation works in sign-magnitude form: partial-product bits that land
// in result columns below DROP are discarded before the magnitude is summed, and
// the sign is re-applied afterwards. DROP=0 makes the approximation exact.
module amul8x8 #(
    parameter int DROP = 0
) (
    input  logic signed [7:0]  x,
    input  logic signed [7:0]  y,
    output logic signed [15:0] exact,
    output logic signed [15:0] approx
);

    // Columns at or above DROP are kept.
    localparam logic [15:0] KEEP = 16'hFFFF << DROP;

    logic signed [15:0] x_ext;
    logic signed [15:0] y_ext;
    logic [7:0]         mag_x;
    logic [7:0]         mag_y;
    logic               neg;
    logic [15:0]        row;
    logic [15:0]        mag_p;

    assign x_ext = {{8{x[7]}}, x};
    assign y_ext = {{8{y[7]}}, y};
    assign exact = x_ext * y_ext;

    // |-128| is 128, which still fits in an unsigned 8-bit magnitude.
    assign mag_x = x[7] ? 8'(-x) : 8'(x);
    assign mag_y = y[7] ? 8'(-y) : 8'(y);
    assign neg   = x[7] ^ y[7];

    // Sum the masked partial-product rows of the magnitude multiply.
    always_comb begin
        row   = '0;
        mag_p = '0;
        for (int i = 0; i < 8; i++) begin
            row   = ({8'b0, mag_y} & {16{mag_x[i]}}) << i;
            mag_p = mag_p + (row & KEEP);
        end
    end

    assign approx = neg ? 16'(-mag_p) : 16'(mag_p);

endmodule

// File: rtl/amul_dot_seq.sv
// Dot-product sequencer around one shared amul8x8: streams a run of operand
// pairs, accumulates exact and approximate sums side by side, tracks the worst
// per-product error, and presents one result record per run.
//
// Handshakes: a pair moves when in_valid && in_ready on a rising edge; a record
// moves when out_valid && out_ready on a rising edge. in_ready and out_valid
// depend only on state, never on the partner's valid/ready, and the record is
// held stable while out_valid is high and out_ready is low.
module amul_dot_seq
    import amul_pkg::*;
#(
    parameter int DROP  = 0,
    parameter int LEN_W = 8,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [7:0]       in_x,
    input  logic signed [7:0]       in_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] acc_exact,
    output logic signed [ACC_W-1:0] acc_approx,
    output logic signed [ACC_W-1:0] err_sum,
    output logic [ERR_W-1:0]        err_max,
    output logic [1:0]              fsm_state
);

    state_t state;
    state_t next_state;

    logic                    xfer;
    logic [LEN_W-1:0]        remaining;
    logic signed [MUL_W-1:0] m_exact;
    logic signed [MUL_W-1:0] m_approx;
    logic signed [MUL_W-1:0] p_exact;
    logic signed [MUL_W-1:0] p_approx;
    logic                    p_vld;
    logic signed [ACC_W-1:0] acc_exact_nxt;
    logic signed [ACC_W-1:0] acc_approx_nxt;
    logic signed [ERR_W-1:0] err_d;
    logic [ERR_W-1:0]        err_abs;

    // The multiplier sees the live operand bus; its result is captured only on a transfer.
    amul8x8 #(.DROP(DROP)) u_mul (
        .x      (in_x),
        .y      (in_y),
        .exact  (m_exact),
        .approx (m_approx)
    );

    assign xfer      = in_valid && in_ready;
    assign fsm_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (xfer && remaining == LEN_W'(1)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                next_state = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state alone.
    always_comb begin
        in_ready  = (state == RUN);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Products are sign-extended before summing; sums wrap modulo 2^ACC_W.
    assign acc_exact_nxt  = acc_exact  + ACC_W'(p_exact);
    assign acc_approx_nxt = acc_approx + ACC_W'(p_approx);
    assign err_d          = ERR_W'(p_exact) - ERR_W'(p_approx);
    assign err_abs        = abs_err(err_d);

    // Product stage, run counter, accumulators and error statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_exact    <= '0;
            p_approx   <= '0;
            p_vld      <= 1'b0;
            remaining  <= '0;
            acc_exact  <= '0;
            acc_approx <= '0;
            err_sum    <= '0;
            err_max    <= '0;
        end else begin
            p_vld <= xfer;
            if (xfer) begin
                p_exact   <= m_exact;
                p_approx  <= m_approx;
                remaining <= remaining - LEN_W'(1);
            end
            if (state == IDLE && start) begin
                // A zero-length run lands in DONE with these cleared values.
                remaining  <= len;
                acc_exact  <= '0;
                acc_approx <= '0;
                err_sum    <= '0;
                err_max    <= '0;
            end else if (p_vld) begin
                acc_exact  <= acc_exact_nxt;
                acc_approx <= acc_approx_nxt;
                // Built from the updated sums so the record is complete in DONE.
                err_sum    <= acc_exact_nxt - acc_approx_nxt;
                if (err_abs > err_max) begin
                    err_max <= err_abs;
                end
            end
        end
    end

endmodule

// File: tb/tb_amul_dot_seq.sv
// Directed and random bench for amul_dot_seq. Two instances share every input:
// one exact (DROP=0, 32-bit sums) and one approximate with narrow sums
// (DROP=3, 16-bit sums), each checked against its own software model.
module tb_amul_dot_seq;

    localparam int LEN_W = 8;
    localparam int DROP1 = 3;
    localparam int R0_W  = 32 * 3 + 17;
    localparam int R1_W  = 16 * 3 + 17;

    // Clock and reset.
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               start     = 1'b0;
    logic [LEN_W-1:0]   len       = '0;
    logic               in_valid  = 1'b0;
    logic signed [7:0]  in_x      = '0;
    logic signed [7:0]  in_y      = '0;
    logic               out_ready = 1'b0;

    logic        busy0, in_ready0, out_valid0;
    logic [31:0] acc_exact0, acc_approx0, err_sum0;
    logic [16:0] err_max0;
    logic [1:0]  fsm0;
    logic        busy1, in_ready1, out_valid1;
    logic [15:0] acc_exact1, acc_approx1, err_sum1;
    logic [16:0] err_max1;
    logic [1:0]  fsm1;

    amul_dot_seq #(.DROP(0), .LEN_W(LEN_W), .ACC_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy0),
        .in_valid(in_valid), .in_ready(in_ready0), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid0), .out_ready(out_ready),
        .acc_exact(acc_exact0), .acc_approx(acc_approx0), .err_sum(err_sum0),
        .err_max(err_max0), .fsm_state(fsm0)
    );

    amul_dot_seq #(.DROP(DROP1), .LEN_W(LEN_W), .ACC_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy1),
        .in_valid(in_valid), .in_ready(in_ready1), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid1), .out_ready(out_ready),
        .acc_exact(acc_exact1), .acc_approx(acc_approx1), .err_sum(err_sum1),
        .err_max(err_max1), .fsm_state(fsm1)
    );

    // Scoreboard.
    int checks = 0;
    int passes = 0;
    logic [R0_W-1:0] exp0_q[$];
    logic [R1_W-1:0] exp1_q[$];

    // Running model of the current run.
    int          m_ex0, m_ap0, m_em0;
    logic [15:0] m_ex1, m_ap1;
    int          m_em1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Reference approximate product: sign-magnitude, partial-product bits in
    // columns below drop discarded.
    function automatic int ref_approx(input int x, input int y, input int drop);
        int ax, ay, s;
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        s  = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (ax[i] && ay[j] && (i + j) >= drop) s += (1 << (i + j));
        return ((x < 0) != (y < 0)) ? -s : s;
    endfunction

    task automatic model_reset();
        m_ex0 = 0; m_ap0 = 0; m_em0 = 0;
        m_ex1 = '0; m_ap1 = '0; m_em1 = 0;
    endtask

    task automatic model_add(input int x, input int y);
        int ex, a0, a1, d;
        ex = x * y;
        a0 = ref_approx(x, y, 0);
        a1 = ref_approx(x, y, DROP1);
        m_ex0 += ex;
        m_ap0 += a0;
        d = (ex > a0) ? ex - a0 : a0 - ex;
        if (d > m_em0) m_em0 = d;
        m_ex1 = m_ex1 + 16'(ex);
        m_ap1 = m_ap1 + 16'(a1);
        d = (ex > a1) ? ex - a1 : a1 - ex;
        if (d > m_em1) m_em1 = d;
    endtask

    task automatic finish_run();
        exp0_q.push_back({32'(m_ex0), 32'(m_ap0), 32'(m_ex0 - m_ap0), 17'(m_em0)});
        exp1_q.push_back({m_ex1, m_ap1, 16'(m_ex1 - m_ap1), 17'(m_em1)});
    endtask

    // Driver: pulse start for one edge; leaves time at #1 after that edge.
    task automatic begin_run(input int l);
        model_reset();
        start = 1'b1;
        len   = LEN_W'(l);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Driver: offer one pair after an optional idle gap; returns #1 after the
    // transfer edge with in_valid still high.
    task automatic send_pair(input logic signed [7:0] x, input logic signed [7:0] y, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        n = 0;
        while (!in_ready0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("xfer_ready", 64'(in_ready0), 64'd1);
        @(posedge clk); #1;
        model_add(int'(x), int'(y));
    endtask

    task automatic cmp_rec(input string tag, input logic [R0_W-1:0] e0, input logic [R1_W-1:0] e1);
        chk({tag, "_ex0"}, 64'(acc_exact0),  64'(e0[112:81]));
        chk({tag, "_ap0"}, 64'(acc_approx0), 64'(e0[80:49]));
        chk({tag, "_es0"}, 64'(err_sum0),    64'(e0[48:17]));
        chk({tag, "_em0"}, 64'(err_max0),    64'(e0[16:0]));
        chk({tag, "_ex1"}, 64'(acc_exact1),  64'(e1[64:49]));
        chk({tag, "_ap1"}, 64'(acc_approx1), 64'(e1[48:33]));
        chk({tag, "_es1"}, 64'(err_sum1),    64'(e1[32:17]));
        chk({tag, "_em1"}, 64'(err_max1),    64'(e1[16:0]));
    endtask

    // Wait for a record, compare it against the queue head, hold it for `hold`
    // cycles (optionally poking start), then take it.
    task automatic get_result(input string tag, input int hold, input bit poke_start);
        int n;
        logic [R0_W-1:0] e0;
        logic [R1_W-1:0] e1;
        n = 0;
        @(negedge clk);
        while (!out_valid0 && n < 400) begin @(negedge clk); n++; end
        chk({tag, "_out_valid"}, 64'(out_valid0), 64'd1);
        chk({tag, "_queued"}, 64'(exp0_q.size() > 0 && exp1_q.size() > 0), 64'd1);
        if (exp0_q.size() > 0 && exp1_q.size() > 0) begin
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            for (int k = 0; k < hold; k++) begin
                cmp_rec({tag, "_hold"}, e0, e1);
                chk({tag, "_hold_ov"}, 64'(out_valid0), 64'd1);
                chk({tag, "_hold_ir"}, 64'(in_ready0), 64'd0);
                if (poke_start && k == 1) begin start = 1'b1; len = 8'd5; end
                if (k == 2) start = 1'b0;
                @(negedge clk);
            end
            start = 1'b0;
            cmp_rec(tag, e0, e1);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_ov_drop"}, 64'(out_valid0), 64'd0);
            chk({tag, "_idle"}, 64'(busy0), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        model_reset();

        // Reset state.
        #12;
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_in_ready", 64'(in_ready0), 64'd0);
        chk("rst_out_valid", 64'(out_valid0), 64'd0);
        chk("rst_acc_exact", 64'(acc_exact0), 64'd0);
        chk("rst_err_max1", 64'(err_max1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic run, continuous valid, latency N+2.
        begin_run(3);
        send_pair(8'sd3, 8'sd4, 0);
        send_pair(-8'sd5, 8'sd6, 0);
        send_pair(8'sd127, -8'sd128, 0);
        in_valid = 1'b0;
        finish_run();
        @(negedge clk);
        chk("lat_n1_out_valid", 64'(out_valid0), 64'd0);
        chk("lat_n1_in_ready", 64'(in_ready0), 64'd0);
        @(negedge clk);
        chk("lat_n2_out_valid", 64'(out_valid0), 64'd1);
        chk("basic_acc_exact", 64'(acc_exact0), 64'(32'hFFFF_C06E));
        get_result("basic", 0, 1'b0);

        // Zero-length run.
        begin_run(0);
        chk("len0_in_ready", 64'(in_ready0), 64'd0);
        finish_run();
        @(negedge clk);
        chk("len0_out_valid", 64'(out_valid0), 64'd1);
        chk("len0_in_ready2", 64'(in_ready0), 64'd0);
        get_result("len0", 0, 1'b0);

        // Output backpressure with an ignored start pulse.
        begin_run(3);
        send_pair(8'sd3, 8'sd4, 0);
        send_pair(-8'sd5, 8'sd6, 1);
        send_pair(8'sd127, -8'sd128, 2);
        in_valid = 1'b0;
        finish_run();
        get_result("bp", 5, 1'b1);

        // Accumulator wrap on the 16-bit instance.
        begin_run(2);
        send_pair(-8'sd128, -8'sd128, 0);
        send_pair(-8'sd128, -8'sd128, 0);
        in_valid = 1'b0;
        finish_run();
        @(negedge clk);
        @(negedge clk);
        chk("wrap_acc_exact1", 64'(acc_exact1), 64'h8000);
        chk("wrap_acc_exact0", 64'(acc_exact0), 64'd32768);
        get_result("wrap", 0, 1'b0);

        // Asynchronous reset in the middle of a run.
        begin_run(5);
        send_pair(8'sd10, 8'sd10, 0);
        send_pair(8'sd20, 8'sd20, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy0), 64'd0);
        chk("arst_in_ready", 64'(in_ready0), 64'd0);
        chk("arst_out_valid", 64'(out_valid0), 64'd0);
        chk("arst_acc_exact0", 64'(acc_exact0), 64'd0);
        chk("arst_acc_approx1", 64'(acc_approx1), 64'd0);
        chk("arst_state", 64'(fsm0), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        begin_run(1);
        send_pair(8'sd2, 8'sd3, 0);
        in_valid = 1'b0;
        finish_run();
        @(negedge clk);
        @(negedge clk);
        chk("arst_fresh_exact", 64'(acc_exact0), 64'd6);
        get_result("fresh", 0, 1'b0);

        // Random run with input and output gaps.
        begin_run(200);
        for (int i = 0; i < 200; i++) begin
            send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end
        in_valid = 1'b0;
        finish_run();
        get_result("rand200", int'($urandom_range(0, 3)), 1'b0);

        // Short random run immediately after, back to back.
        begin_run(17);
        for (int i = 0; i < 17; i++) begin
            send_pair(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      int'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        finish_run();
        get_result("rand17", int'($urandom_range(1, 4)), 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
